// File: rtl/regfile_dp.sv
// ============================================================================
// regfile_dp: dual-write / triple-read ARM register file with PC substitution
//             and a handshaked debug dump engine.   Revision: 1.0
// ============================================================================
`default_nettype none

module regfile_dp #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16,
  parameter int BYPASS = 0,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AW-1:0]     ra1,
  input  logic [AW-1:0]     ra2,
  input  logic [AW-1:0]     ra3,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic [DATA_W-1:0] rd3,
  input  logic [DATA_W-1:0] r15,
  input  logic              we3,
  input  logic [AW-1:0]     wa3,
  input  logic [DATA_W-1:0] wd3,
  input  logic              we4,
  input  logic [AW-1:0]     wa4,
  input  logic [DATA_W-1:0] wd4,
  input  logic              dbg_start,
  output logic              dbg_valid,
  input  logic              dbg_ready,
  output logic [AW-1:0]     dbg_idx,
  output logic [DATA_W-1:0] dbg_data,
  output logic              dbg_busy,
  output logic              dbg_done
);

  localparam logic [AW-1:0] PC_IDX   = AW'(NREGS - 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  logic [DATA_W-1:0] regs_q [NREGS-1];
  logic [DATA_W-1:0] regs_d [NREGS-1];

  state_t            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Port B is applied first so that port A overwrites it on an address clash.
  always_comb begin
    regs_d = regs_q;
    if (we4 && (wa4 != PC_IDX)) begin
      regs_d[wa4] = wd4;
    end
    if (we3 && (wa3 != PC_IDX)) begin
      regs_d[wa3] = wd3;
    end
  end

  for (genvar p = 0; p < 3; p++) begin : g_rd
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] val;

    assign addr = (p == 0) ? ra1 : ((p == 1) ? ra2 : ra3);

    always_comb begin
      val = '0;
      if (addr == PC_IDX) begin
        val = r15;
      end else if ((BYPASS != 0) && we3 && (wa3 == addr)) begin
        val = wd3;
      end else if ((BYPASS != 0) && we4 && (wa4 == addr)) begin
        val = wd4;
      end else begin
        val = regs_q[addr];
      end
    end
  end

  assign rd1 = g_rd[0].val;
  assign rd2 = g_rd[1].val;
  assign rd3 = g_rd[2].val;

  // Beats are loaded from regs_q, so a write landing on the load edge is excluded.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (dbg_start) begin
          state_d = SEND;
          idx_d   = '0;
          data_d  = regs_q[0];
        end
      end
      SEND: begin
        if (dbg_ready) begin
          if (idx_q < LAST_IDX) begin
            idx_d  = idx_q + AW'(1);
            data_d = regs_q[idx_q + AW'(1)];
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREGS - 1; i++) begin
        regs_q[i] <= '0;
      end
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      regs_q  <= regs_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  assign dbg_valid = (state_q == SEND);
  assign dbg_busy  = (state_q != IDLE);
  assign dbg_done  = (state_q == DONE);
  assign dbg_idx   = idx_q;
  assign dbg_data  = data_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_dp.sv
// Bench for regfile_dp: two instances (BYPASS=0 and BYPASS=1) share stimulus and
// are checked every cycle against an array model plus directed literal checks.
`default_nettype none

module tb_regfile_dp;

  localparam int DW = 32;
  localparam int NR = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] ra1, ra2, ra3, wa3, wa4;
  logic [DW-1:0] r15, wd3, wd4;
  logic          we3, we4, dbg_start, dbg_ready;

  logic [DW-1:0] rd1_0, rd2_0, rd3_0, data_0, rd1_1, rd2_1, rd3_1, data_1;
  logic [AW-1:0] idx_0, idx_1;
  logic          valid_0, busy_0, done_0, valid_1, busy_1, done_1;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  regfile_dp #(.DATA_W(DW), .NREGS(NR), .BYPASS(0)) dut0 (
    .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .ra3(ra3),
    .rd1(rd1_0), .rd2(rd2_0), .rd3(rd3_0), .r15(r15),
    .we3(we3), .wa3(wa3), .wd3(wd3), .we4(we4), .wa4(wa4), .wd4(wd4),
    .dbg_start(dbg_start), .dbg_valid(valid_0), .dbg_ready(dbg_ready),
    .dbg_idx(idx_0), .dbg_data(data_0), .dbg_busy(busy_0), .dbg_done(done_0)
  );

  regfile_dp #(.DATA_W(DW), .NREGS(NR), .BYPASS(1)) dut1 (
    .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .ra3(ra3),
    .rd1(rd1_1), .rd2(rd2_1), .rd3(rd3_1), .r15(r15),
    .we3(we3), .wa3(wa3), .wd3(wd3), .we4(we4), .wa4(wa4), .wd4(wd4),
    .dbg_start(dbg_start), .dbg_valid(valid_1), .dbg_ready(dbg_ready),
    .dbg_idx(idx_1), .dbg_data(data_1), .dbg_busy(busy_1), .dbg_done(done_1)
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  logic [DW-1:0] m_regs [NR-1];
  int            m_phase;   // 0 idle, 1 sending, 2 done pulse
  int            m_beat;
  logic [DW-1:0] m_bdata;

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NR - 1; i++) m_regs[i] = '0;
      m_phase = 0;
      m_beat  = 0;
      m_bdata = '0;
    end else begin
      if (m_phase == 0) begin
        if (dbg_start) begin
          m_phase = 1; m_beat = 0; m_bdata = m_regs[0];
        end
      end else if (m_phase == 1) begin
        if (dbg_ready) begin
          if (m_beat == NR - 2) m_phase = 2;
          else begin
            m_beat  = m_beat + 1;
            m_bdata = m_regs[m_beat];
          end
        end
      end else begin
        m_phase = 0;
      end
      if (we4 && int'(wa4) != NR - 1) m_regs[wa4] = wd4;
      if (we3 && int'(wa3) != NR - 1) m_regs[wa3] = wd3;
    end
  end

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a, input bit byp);
    if (int'(a) == NR - 1) return r15;
    if (byp && we3 && wa3 == a) return wd3;
    if (byp && we4 && wa4 == a) return wd4;
    return m_regs[a];
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("rd1_b0", rd1_0, m_read(ra1, 1'b0));
      check("rd2_b0", rd2_0, m_read(ra2, 1'b0));
      check("rd3_b0", rd3_0, m_read(ra3, 1'b0));
      check("rd1_b1", rd1_1, m_read(ra1, 1'b1));
      check("rd2_b1", rd2_1, m_read(ra2, 1'b1));
      check("rd3_b1", rd3_1, m_read(ra3, 1'b1));
      check("valid0", 32'(valid_0), 32'(m_phase == 1));
      check("busy0",  32'(busy_0),  32'(m_phase != 0));
      check("done0",  32'(done_0),  32'(m_phase == 2));
      check("valid1", 32'(valid_1), 32'(m_phase == 1));
      check("done1",  32'(done_1),  32'(m_phase == 2));
      if (m_phase == 1) begin
        check("idx0",  32'(idx_0), 32'(m_beat));
        check("data0", data_0, m_bdata);
        check("data1", data_1, m_bdata);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] bdata [$];
  int            bidx  [$];
  int            done_cnt;
  int            post;
  bit            wrote;
  bit            pat [4];

  initial begin
    reset = 1'b0; r15 = 32'h0000_1008;
    ra1 = '0; ra2 = '0; ra3 = '0; wa3 = '0; wa4 = '0; wd3 = '0; wd4 = '0;
    we3 = 1'b0; we4 = 1'b0; dbg_start = 1'b0; dbg_ready = 1'b0;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    step(); step();
    reset = 1'b1;
    chk_en = 1'b1;

    @(negedge clk);
    check("rst_valid", 32'(valid_0), 32'd0);
    check("rst_busy",  32'(busy_0),  32'd0);
    check("rst_done",  32'(done_0),  32'd0);
    check("rst_idx",   32'(idx_0),   32'd0);
    check("rst_data",  data_0,       32'd0);

    for (int a = 0; a < NR - 1; a++) begin
      step();
      ra1 = AW'(a); ra2 = AW'(a); ra3 = AW'(a);
      @(negedge clk);
      check("rst_rd1", rd1_0, 32'd0);
      check("rst_rd3", rd3_1, 32'd0);
    end
    step();
    ra1 = 4'd15;
    @(negedge clk);
    check("pc_rd1", rd1_0, 32'h0000_1008);

    // same-address collision: port A wins
    step();
    we3 = 1'b1; wa3 = 4'd4; wd3 = 32'hAAAA_0001;
    we4 = 1'b1; wa4 = 4'd4; wd4 = 32'hBBBB_0002;
    step();
    we3 = 1'b0; we4 = 1'b0; ra1 = 4'd4;
    @(negedge clk);
    check("collide_b0", rd1_0, 32'hAAAA_0001);
    check("collide_b1", rd1_1, 32'hAAAA_0001);

    // dual write to distinct addresses
    step();
    we3 = 1'b1; wa3 = 4'd2; wd3 = 32'h2222_0002;
    we4 = 1'b1; wa4 = 4'd7; wd4 = 32'h7777_0007;
    step();
    we3 = 1'b0; we4 = 1'b0; ra1 = 4'd2; ra2 = 4'd7;
    @(negedge clk);
    check("dual_a", rd1_0, 32'h2222_0002);
    check("dual_b", rd2_0, 32'h7777_0007);

    // PC write is discarded and never forwarded
    step();
    we3 = 1'b1; wa3 = 4'd15; wd3 = 32'hDEAD_BEEF; ra1 = 4'd15;
    @(negedge clk);
    check("pcw_same_b1", rd1_1, 32'h0000_1008);
    step();
    we3 = 1'b0;
    @(negedge clk);
    check("pcw_next_b0", rd1_0, 32'h0000_1008);

    // bypass vs stored read
    step();
    we3 = 1'b1; wa3 = 4'd5; wd3 = 32'h1234_5678; ra2 = 4'd5;
    @(negedge clk);
    check("byp_same_b1", rd2_1, 32'h1234_5678);
    check("byp_same_b0", rd2_0, 32'h0000_0000);
    step();
    we3 = 1'b0;
    @(negedge clk);
    check("byp_next_b0", rd2_0, 32'h1234_5678);

    // fill regs i = 0x100+i (wa4=15 on last pass is discarded)
    for (int i = 0; i < 8; i++) begin
      step();
      we3 = 1'b1; wa3 = AW'(2 * i);     wd3 = 32'h100 + 32'(2 * i);
      we4 = 1'b1; wa4 = AW'(2 * i + 1); wd4 = 32'h100 + 32'(2 * i + 1);
    end
    step();
    we3 = 1'b0; we4 = 1'b0; dbg_start = 1'b1;

    // dump with backpressure, a mid-dump start, a write under a held beat
    done_cnt = 0; post = 0; wrote = 1'b0;
    for (int c = 0; c < 300 && post < 4; c++) begin
      step();
      we3 = 1'b0;
      dbg_start = (c == 5) || done_0;
      dbg_ready = pat[c % 4];
      if (valid_0 && idx_0 == 4'd3 && !wrote) begin
        we3 = 1'b1; wa3 = 4'd3; wd3 = 32'h9999_0003; dbg_ready = 1'b0; wrote = 1'b1;
      end
      @(negedge clk);
      if (valid_0 && dbg_ready) begin
        bidx.push_back(int'(idx_0));
        bdata.push_back(data_0);
      end
      if (done_0) done_cnt++;
      if (done_cnt > 0) post++;
    end
    dbg_start = 1'b0;
    check("beat_count", 32'(bidx.size()), 32'd15);
    for (int i = 0; i < bidx.size() && i < 15; i++) begin
      check("beat_idx",  32'(bidx[i]), 32'(i));
      check("beat_data", bdata[i], 32'h100 + 32'(i));
    end
    check("done_once", 32'(done_cnt), 32'd1);
    check("idle_after", 32'(busy_0), 32'd0);
    step();
    ra1 = 4'd3;
    @(negedge clk);
    check("r3_written", rd1_0, 32'h9999_0003);

    // reset in the middle of a zero-stall dump
    step();
    dbg_start = 1'b1; dbg_ready = 1'b1;
    step();
    dbg_start = 1'b0;
    for (int c = 0; c < 40 && idx_0 != 4'd6; c++) step();
    check("reached_beat6", 32'(idx_0), 32'd6);
    reset = 1'b0;
    step();
    reset = 1'b1;
    @(negedge clk);
    check("mrst_valid", 32'(valid_0), 32'd0);
    check("mrst_busy",  32'(busy_0),  32'd0);
    check("mrst_done",  32'(done_0),  32'd0);
    for (int a = 0; a < NR - 1; a++) begin
      step();
      ra1 = AW'(a);
      @(negedge clk);
      check("mrst_reg", rd1_0, 32'd0);
      check("mrst_nodone", 32'(done_0), 32'd0);
    end
    step();
    dbg_start = 1'b1;
    step();
    dbg_start = 1'b0;
    @(negedge clk);
    check("restart_valid", 32'(valid_0), 32'd1);
    check("restart_idx",   32'(idx_0),   32'd0);
    check("restart_data",  data_0,       32'd0);
    for (int c = 0; c < 20; c++) step();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
